// File: rtl/wave_seq.sv
// wave_seq: table-driven sequencer that programs wave_gen through its register port.
// Define WAVE_SEQ_IRQ_EN to add the done interrupt (irq port, CTRL bit3 IRQ_ENABLE).
module wave_seq #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  gen_wstrb,
  output logic [31:0] gen_addr,
  output logic [31:0] gen_wdata
`ifdef WAVE_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam logic [4:0]  DepthC = 5'(DEPTH);

  typedef enum logic [2:0] {
    StRstOff, StIdle, StWrMode, StWrP1, StWrP2, StHold, StWrOff
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     hold_q, hold_d;
  logic [4:0]      count_q;
  logic            loop_q, done_q, stopping_q, ready_q;
  logic [31:0]     rdata_q, rd_mux;

  logic [2:0]      mode_q [DEPTH];
  logic [31:0]     p1_q   [DEPTH];
  logic [31:0]     p2_q   [DEPTH];
  logic [31:0]     dur_q  [DEPTH];

  logic            accept, is_wr, is_rd, ctrl_wr, count_wr, tbl_wr;
  logic            start_req, stop_req, busy, entry_ok;
  logic [IdxW-1:0] entry;
  logic [4:0]      idx_inc;
  logic [7:0]      idx_ext;
  logic [31:0]     ctrl_rd, status_rd;
  logic            unused_addr;

  // A held valid is only taken once; the ready cycle blocks re-acceptance.
  assign accept    = valid & ~ready_q;
  assign is_wr     = accept & (|wstrb);
  assign is_rd     = accept & ~(|wstrb);
  assign ctrl_wr   = is_wr & ~addr[8] & (addr[7:2] == 6'd0);
  assign count_wr  = is_wr & ~addr[8] & (addr[7:2] == 6'd1);
  assign start_req = ctrl_wr & wdata[0];
  assign stop_req  = ctrl_wr & wdata[2];
  assign busy      = (state_q != StIdle) && (state_q != StRstOff);
  assign entry     = addr[4 +: IdxW];
  assign entry_ok  = ({28'b0, addr[7:4]} < DEPTH);
  assign tbl_wr    = is_wr & addr[8] & entry_ok & ~busy;

  assign idx_inc   = {{(5 - IdxW){1'b0}}, idx_q} + 5'd1;
  assign idx_ext   = {{(8 - IdxW){1'b0}}, idx_q};
  assign status_rd = {16'b0, idx_ext, 5'b0, done_q, stopping_q, busy};

  assign unused_addr = ^{addr[31:9], addr[1:0]};

`ifdef WAVE_SEQ_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= wdata[3];
      irq_q <= irq_en_q && (state_q == StWrOff);
    end
  end

  assign irq     = irq_q;
  assign ctrl_rd = {28'b0, irq_en_q, 1'b0, loop_q, 1'b0};
`else
  assign ctrl_rd = {30'b0, loop_q, 1'b0};
`endif

  always_comb begin
    rd_mux = '0;
    if (addr[8]) begin
      if (entry_ok) begin
        unique case (addr[3:2])
          2'd0:    rd_mux = {29'b0, mode_q[entry]};
          2'd1:    rd_mux = p1_q[entry];
          2'd2:    rd_mux = p2_q[entry];
          default: rd_mux = dur_q[entry];
        endcase
      end
    end else begin
      case (addr[7:2])
        6'd0:    rd_mux = ctrl_rd;
        6'd1:    rd_mux = {27'b0, count_q};
        6'd2:    rd_mux = status_rd;
        default: rd_mux = '0;
      endcase
    end
  end

  // Generator port is decoded from state and idx only; rst merely masks the
  // power-on OFF write while reset is still held.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    gen_wstrb = 4'h0;
    gen_addr  = '0;
    gen_wdata = '0;
    unique case (state_q)
      StRstOff: begin
        gen_wstrb = rst ? 4'h0 : 4'hF;
        state_d   = StIdle;
      end
      StIdle: begin
        if (start_req && !stop_req && (count_q != 5'd0)) begin
          idx_d   = '0;
          state_d = StWrMode;
        end
      end
      StWrMode: begin
        gen_wstrb = 4'hF;
        gen_wdata = {29'b0, mode_q[idx_q]};
        state_d   = stop_req ? StWrOff : StWrP1;
      end
      StWrP1: begin
        gen_wstrb = 4'hF;
        gen_addr  = 32'h4;
        gen_wdata = p1_q[idx_q];
        state_d   = stop_req ? StWrOff : StWrP2;
      end
      StWrP2: begin
        gen_wstrb = 4'hF;
        gen_addr  = 32'h8;
        gen_wdata = p2_q[idx_q];
        hold_d    = (dur_q[idx_q] == 32'd0) ? 32'd1 : dur_q[idx_q];
        state_d   = stop_req ? StWrOff : StHold;
      end
      StHold: begin
        if (stop_req) begin
          state_d = StWrOff;
        end else if (hold_q <= 32'd1) begin
          if (idx_inc < count_q) begin
            idx_d   = idx_inc[IdxW-1:0];
            state_d = StWrMode;
          end else if (loop_q) begin
            idx_d   = '0;
            state_d = StWrMode;
          end else begin
            state_d = StWrOff;
          end
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      StWrOff: begin
        gen_wstrb = 4'hF;
        state_d   = StIdle;
      end
      default: state_d = StRstOff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRstOff;
      idx_q      <= '0;
      hold_q     <= '0;
      count_q    <= '0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
      stopping_q <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      ready_q <= accept;
      rdata_q <= is_rd ? rd_mux : '0;
      if (count_wr) count_q <= (wdata > DEPTH) ? DepthC : wdata[4:0];
      if (ctrl_wr)  loop_q  <= wdata[1];
      if (state_q == StWrOff) begin
        done_q <= 1'b1;
      end else if ((state_q == StIdle) && (state_d == StWrMode)) begin
        done_q <= 1'b0;
      end
      // Held through the first IDLE cycle so software can see the stop landed.
      if (stop_req && busy) begin
        stopping_q <= 1'b1;
      end else if (state_q == StIdle) begin
        stopping_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mode_q[i] <= '0;
        p1_q[i]   <= '0;
        p2_q[i]   <= '0;
        dur_q[i]  <= '0;
      end
    end else if (tbl_wr) begin
      unique case (addr[3:2])
        2'd0:    mode_q[entry] <= wdata[2:0];
        2'd1:    p1_q[entry]   <= wdata;
        2'd2:    p2_q[entry]   <= wdata;
        default: dur_q[entry]  <= wdata;
      endcase
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_wave_seq.sv
// Self-checking bench for wave_seq: register vectors, directed sequences and
// randomized step tables checked against a timing-rule model of generator writes.
module tb_wave_seq;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, valid, ready;
  logic [3:0]  wstrb, gen_wstrb;
  logic [31:0] addr, wdata, rdata, gen_addr, gen_wdata;
`ifdef WAVE_SEQ_IRQ_EN
  logic        irq;
`endif

  wave_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .ready     (ready),
    .wstrb     (wstrb),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .gen_wstrb (gen_wstrb),
    .gen_addr  (gen_addr),
    .gen_wdata (gen_wdata)
`ifdef WAVE_SEQ_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } gw_t;

  gw_t log_q[$];
  gw_t exp_q[$];
  always @(negedge clk) begin
    if (gen_wstrb != 4'h0) log_q.push_back('{cyc, gen_addr, gen_wdata, gen_wstrb});
  end

`ifdef WAVE_SEQ_IRQ_EN
  int irq_q[$];
  always @(negedge clk) begin
    if (irq) irq_q.push_back(cyc);
  end
`endif

  int checks = 0;
  int failures = 0;
  int last_t, end_cyc, rel, t, s, cnt;
  logic [31:0] rv, v;

  logic [2:0]  m_mode [DEPTH];
  logic [31:0] m_p1   [DEPTH];
  logic [31:0] m_p2   [DEPTH];
  logic [31:0] m_dur  [DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ta(input int e, input int f);
    return 32'h100 | (32'(e) << 4) | (32'(f) << 2);
  endfunction

  // Called at posedge+1; returns at posedge+1 two cycles later.
  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    valid  = 1'b1;
    wstrb  = we ? 4'hF : 4'h0;
    addr   = a;
    wdata  = d;
    last_t = cyc;
    @(posedge clk); #1;
    valid = 1'b0;
    wstrb = 4'h0;
    @(negedge clk);
    check("ready", {31'b0, ready}, 32'd1);
    rd = rdata;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    bus(1'b0, a, 32'h0, q);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic prog(input int e, input logic [2:0] m, input logic [31:0] a1,
                      input logic [31:0] a2, input logic [31:0] dr);
    wr(ta(e, 0), {29'b0, m});
    wr(ta(e, 1), a1);
    wr(ta(e, 2), a2);
    wr(ta(e, 3), dr);
    m_mode[e] = m;
    m_p1[e]   = a1;
    m_p2[e]   = a2;
    m_dur[e]  = dr;
  endtask

  // Each step: three writes right after the cursor, then max(DUR,1) hold cycles.
  task automatic model_run(input int t0, input int n);
    int cur;
    int d;
    cur = t0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      d = (m_dur[i] == 32'd0) ? 1 : int'(m_dur[i]);
      exp_q.push_back('{cur + 1, 32'h0, {29'b0, m_mode[i]}, 4'hF});
      exp_q.push_back('{cur + 2, 32'h4, m_p1[i], 4'hF});
      exp_q.push_back('{cur + 3, 32'h8, m_p2[i], 4'hF});
      cur = cur + 3 + d;
    end
    exp_q.push_back('{cur + 1, 32'h0, 32'h0, 4'hF});
    end_cyc = cur + 1;
  endtask

  task automatic cmp_log(input string name);
    check($sformatf("%s.count", name), 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s[%0d].cyc", name, i), 32'(log_q[i].c), 32'(exp_q[i].c));
      check($sformatf("%s[%0d].addr", name, i), log_q[i].a, exp_q[i].a);
      check($sformatf("%s[%0d].data", name, i), log_q[i].d, exp_q[i].d);
      check($sformatf("%s[%0d].strb", name, i), {28'b0, log_q[i].s}, {28'b0, exp_q[i].s});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; wstrb = 4'h0; addr = '0; wdata = '0;

    // Reset: outputs quiet while held, one OFF write on release.
    @(posedge clk); @(negedge clk);
    check("rst.gen_wstrb", {28'b0, gen_wstrb}, 32'h0);
    check("rst.ready", {31'b0, ready}, 32'h0);
    check("rst.rdata", rdata, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    repeat (6) begin
      @(posedge clk); #1;
    end
    exp_q.delete();
    exp_q.push_back('{rel, 32'h0, 32'h0, 4'hF});
    cmp_log("reset");

    // Register / table vectors: write (optional) then read back.
    vecs[0]  = '{1'b1, 32'h004, 32'd20, 32'd8};
    vecs[1]  = '{1'b1, 32'h004, 32'd3, 32'd3};
    vecs[2]  = '{1'b1, 32'h004, 32'd8, 32'd8};
    vecs[3]  = '{1'b1, 32'h004, 32'd9, 32'd8};
    vecs[4]  = '{1'b1, 32'h004, 32'd0, 32'd0};
    vecs[5]  = '{1'b1, 32'h124, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 32'h120, 32'h000000FF, 32'h7};
    vecs[7]  = '{1'b1, 32'h19C, 32'h1234, 32'h0};
    vecs[8]  = '{1'b0, 32'h11C, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 32'h000, 32'h2, 32'h2};
    vecs[10] = '{1'b1, 32'h000, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 32'h00C, 32'hFFFF, 32'h0};
    vecs[12] = '{1'b1, 32'h17C, 32'h10000, 32'h10000};
    vecs[13] = '{1'b0, 32'h008, 32'h0, 32'h0};
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].we) wr(vecs[i].a, vecs[i].d);
      rd(vecs[i].a, rv);
      check($sformatf("vec%0d@%h", i, vecs[i].a), rv, vecs[i].exp);
    end

    // Two-step run.
    prog(0, 3'd2, 32'd3, 32'd5, 32'd4);
    prog(1, 3'd5, 32'd10, 32'd2, 32'd0);
    wr(32'h4, 32'd2);
    log_q.delete();
    wr(32'h0, 32'h1);
    t = last_t;
    model_run(t, 2);
    check("two_step.off_at_t12", 32'(end_cyc), 32'(t + 12));
    wait_until(end_cyc + 3);
    cmp_log("two_step");
    rd(32'h8, rv);
    check("two_step.status", {29'b0, rv[2:0]}, 32'h4);

    // START with COUNT=0 is ignored.
    wr(32'h4, 32'd0);
    log_q.delete();
    wr(32'h0, 32'h1);
    wait_until(last_t + 12);
    check("count0.writes", 32'(log_q.size()), 32'd0);
    rd(32'h8, rv);
    check("count0.status", {29'b0, rv[2:0]}, 32'h4);

    // START and STOP together from IDLE do nothing.
    wr(32'h4, 32'd2);
    log_q.delete();
    wr(32'h0, 32'h5);
    wait_until(last_t + 12);
    check("start_stop.writes", 32'(log_q.size()), 32'd0);
    rd(32'h8, rv);
    check("start_stop.status", {29'b0, rv[2:0]}, 32'h4);

    // Table write while busy is dropped.
    log_q.delete();
    wr(32'h0, 32'h1);
    t = last_t;
    wr(ta(0, 1), 32'h55);
    model_run(t, 2);
    wait_until(end_cyc + 3);
    cmp_log("busy_wr");
    rd(ta(0, 1), rv);
    check("busy_wr.readback", rv, 32'd3);

    // Loop wraps to entry0, then STOP during HOLD.
    log_q.delete();
    wr(32'h0, 32'h3);
    t = last_t;
    wait_until(t + 16);
    wr(32'h0, 32'h4);
    s = last_t;
    rd(32'h8, rv);
    check("stop.status_s2", {29'b0, rv[2:0]}, 32'h6);
    rd(32'h8, rv);
    check("stop.status_later", {29'b0, rv[2:0]}, 32'h4);
    exp_q.delete();
    exp_q.push_back('{t + 1, 32'h0, 32'd2, 4'hF});
    exp_q.push_back('{t + 2, 32'h4, 32'd3, 4'hF});
    exp_q.push_back('{t + 3, 32'h8, 32'd5, 4'hF});
    exp_q.push_back('{t + 8, 32'h0, 32'd5, 4'hF});
    exp_q.push_back('{t + 9, 32'h4, 32'd10, 4'hF});
    exp_q.push_back('{t + 10, 32'h8, 32'd2, 4'hF});
    exp_q.push_back('{t + 12, 32'h0, 32'd2, 4'hF});
    exp_q.push_back('{t + 13, 32'h4, 32'd3, 4'hF});
    exp_q.push_back('{t + 14, 32'h8, 32'd5, 4'hF});
    exp_q.push_back('{s + 1, 32'h0, 32'h0, 4'hF});
    wait_until(s + 10);
    cmp_log("loop_stop");

    // Randomized step tables and COUNT clamping.
    for (int r = 0; r < 6; r++) begin
      v = 32'($urandom_range(0, 40));
      wr(32'h4, v);
      rd(32'h4, rv);
      check($sformatf("rand%0d.count_clamp", r), rv, (v > DEPTH) ? DEPTH : v);
      cnt = int'($urandom_range(1, DEPTH));
      for (int e = 0; e < cnt; e++) begin
        prog(e, 3'($urandom_range(0, 7)), $urandom, $urandom, 32'($urandom_range(0, 5)));
      end
      rd(ta(cnt - 1, 2), rv);
      check($sformatf("rand%0d.p2_readback", r), rv, m_p2[cnt - 1]);
      wr(32'h4, 32'(cnt));
      log_q.delete();
      wr(32'h0, 32'h1);
      model_run(last_t, cnt);
      wait_until(end_cyc + 3);
      cmp_log($sformatf("rand%0d", r));
      rd(32'h8, rv);
      check($sformatf("rand%0d.status", r), {29'b0, rv[2:0]}, 32'h4);
    end

`ifdef WAVE_SEQ_IRQ_EN
    // Done interrupt: one pulse at t+6 for a single DUR=1 step, none when disabled.
    prog(0, 3'd1, 32'd7, 32'd9, 32'd1);
    wr(32'h4, 32'd1);
    irq_q.delete();
    wr(32'h0, 32'h9);
    t = last_t;
    wait_until(t + 14);
    check("irq.pulses", 32'(irq_q.size()), 32'd1);
    if (irq_q.size() > 0) check("irq.cycle", 32'(irq_q[0]), 32'(t + 6));
    rd(32'h0, rv);
    check("irq.ctrl_read", rv, 32'h8);
    irq_q.delete();
    wr(32'h0, 32'h1);
    wait_until(last_t + 14);
    check("irq.disabled", 32'(irq_q.size()), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_seq.md
# wave_seq

Programmable sequencer that drives the `wave_gen` register port on behalf of the CPU. It holds a small table of waveform steps. Each step is a mode, two parameters and a hold duration. On start it writes each step into the generator in the required order (MODE, then PARAM1, then PARAM2), holds it for the programmed number of cycles, then advances, with optional looping. It sits on the picosoc iomem bus as a slave, and its master port is wired directly to the generator's `wstrb/addr/wdata` inputs.

## Interface
- `DEPTH`, 8: number of table entries; power of two, 2..16.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous and active-high.
- `valid` input 1: CPU access strobe.
- `ready` output 1: access acknowledge; reset 0.
- `wstrb` input 4: CPU byte strobes; nonzero means write, zero means read.
- `addr` input 32: CPU byte address; uses `addr[8]` and `addr[7:2]`.
- `wdata` input 32: CPU write data.
- `rdata` output 32: CPU read data, valid while `ready`=1; reset 0.
- `gen_wstrb` output 4: generator write strobe; `4'hF` during generator writes, else 0; reset 0.
- `gen_addr` output 32: generator address; only bits [3:2] are nonzero; reset 0.
- `gen_wdata` output 32: generator write data; reset 0.
- `irq` output 1: done pulse; present only with `WAVE_SEQ_IRQ_EN`.

## Operation
- **CPU map, `addr[8]`=0:**
  - word 0 CTRL (write): bit0 START, bit1 LOOP (stored), bit2 STOP. Reads return `{30'b0, loop, 1'b0}`.
  - word 1 COUNT (R/W): number of steps; writes are clamped to DEPTH.
  - word 2 STATUS (RO): `{16'b0, idx[7:0], 5'b0, done, stopping, busy}`.
  - word 3 reads 0.
- **CPU map, `addr[8]`=1:** table access; `addr[7:4]` is the entry and `addr[3:2]` the field (0 MODE[2:0], 1 P1, 2 P2, 3 DUR). Entries ≥ DEPTH read 0 and ignore writes.
- **Bus handshake:** `ready` pulses for 1 cycle, the cycle after `valid` is sampled high. The write takes effect on the `valid` cycle. `rdata` is registered. Back-to-back accesses require `valid` to drop for 1 cycle.
- **FSM states:** RST_OFF, IDLE, WR_MODE, WR_P1, WR_P2, HOLD, WR_OFF.
- **Transitions:**
  - RST_OFF: entered during reset, with outputs 0. In the first cycle after reset it issues MODE←0 (OFF), then goes to IDLE.
  - IDLE: on START with COUNT≠0, set idx←0, clear done, go to WR_MODE. START with COUNT=0 is ignored.
  - WR_MODE, WR_P1, WR_P2: each lasts 1 cycle and issues a generator write of entry[idx] field MODE, P1 or P2 to generator word 0, 1, 2.
  - Entering HOLD loads hold_cnt←max(DUR,1).
  - HOLD: decrements hold_cnt each cycle. When it reaches 1:
    - if idx<COUNT−1: idx+1, go to WR_MODE;
    - else if LOOP: idx←0, go to WR_MODE;
    - else go to WR_OFF.
  - WR_OFF: 1 cycle, issues MODE←0, sets done, clears busy, goes to IDLE.
- **STOP:** in any busy state, finish the current generator write cycle, then go to WR_OFF. `stopping` is high from the STOP write until IDLE.
- **Simultaneous START and STOP:** STOP wins; from IDLE this is a no-op.
- **Writes while busy:** table writes and START are ignored. COUNT and LOOP writes take effect at the next wrap decision.
- **Status bits:** `busy` is 1 in every state except IDLE and RST_OFF. `done` clears on START.
- **Reset mid-sequence:** everything returns to RST_OFF, and the generator is switched OFF on the first post-reset cycle. Table contents are reset to 0.

## Timing
- A START write accepted at cycle t produces generator writes at t+1 (MODE), t+2 (P1) and t+3 (P2).
- HOLD occupies t+4 .. t+3+max(DUR,1).
- The next step's MODE write occurs at t+4+max(DUR,1).
- Per-step period is 3+max(DUR,1) cycles.
- STOP accepted in HOLD at cycle s: WR_OFF write at s+1, IDLE at s+2.
- All outputs are registered, except `gen_*`, which are decoded from the state register and idx with no combinational path from CPU inputs.

## Configuration
- `WAVE_SEQ_IRQ_EN` defined:
  - `irq` is a 1-cycle pulse in the cycle after WR_OFF, on both normal completion and STOP.
  - CTRL bit3 is IRQ_ENABLE; when it is 0, `irq` stays 0.
- `WAVE_SEQ_IRQ_EN` undefined: no `irq` port, and CTRL bit3 is ignored and reads 0.

## Test plan
- **Reset:** assert `rst` for 3 cycles, release → exactly one generator write `addr`=0, `wdata`=0 in the first cycle after release, then `gen_wstrb` stays 0 and STATUS reads 0.
- **Two-step run:**
  - Program entry0 = (PWM=2, P1=3, P2=5, DUR=4) and entry1 = (TRI=5, 10, 2, DUR=0); COUNT=2; START.
  - Expect writes at t+1..t+3 (2, 3, 5), entry1 writes at t+8..t+10, OFF write at t+12.
  - Afterwards `done`=1 and `busy`=0.
- **Loop and stop:**
  - With LOOP=1 and 2 entries, after idx wraps to 0 → entry0 MODE is rewritten.
  - STOP during HOLD → OFF write at s+1, IDLE at s+2, `stopping` observed for 2 cycles.
- **Boundaries:**
  - COUNT write of 20 with DEPTH=8 → reads back 8.
  - START with COUNT=0 → no generator write.
  - Table write while busy → readback unchanged.
  - START+STOP in one write → no activity.
- **IRQ:** with `WAVE_SEQ_IRQ_EN` and IRQ_ENABLE=1, a single entry with DUR=1 → `irq` high for exactly 1 cycle at t+6; with IRQ_ENABLE=0 → `irq` never asserts.
